// File: rtl/pe_mem_loader.sv
// PE memory-write transmitter: turns a header/payload load stream into PE column writes, then pulses start.
// Optional feature macro: PE_MEM_LOADER_CHECKSUM_EN adds a running payload checksum output.
module pe_mem_loader #(
  parameter int memDataLen        = 16,
  parameter int logMemNamespaces  = 2,
  parameter int logNumPeMemColumn = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         load_go,
  input  logic [memDataLen-1:0]        src_data,
  input  logic                         src_valid,
  output logic                         src_ready,
  output logic                         mem_wrt_valid,
  output logic [logNumPeMemColumn-1:0] peId_mem_in,
  output logic [logMemNamespaces-1:0]  mem_data_type,
  output logic [memDataLen-1:0]        mem_data_input,
  output logic                         start,
  output logic                         busy,
  output logic [15:0]                  words_written
`ifdef PE_MEM_LOADER_CHECKSUM_EN
  ,
  output logic [memDataLen-1:0]        checksum
`endif
);

  localparam int cntLen = memDataLen - logMemNamespaces - logNumPeMemColumn;

  typedef enum logic [1:0] {IDLE, HDR, BURST, FIN} state_t;

  state_t                       state;
  logic [logMemNamespaces-1:0]  ns_q;
  logic [logNumPeMemColumn-1:0] pe_q;
  logic [cntLen-1:0]            cnt;

  logic [logMemNamespaces-1:0]  hdr_ns;
  logic [logNumPeMemColumn-1:0] hdr_pe;
  logic [cntLen-1:0]            hdr_cnt;
  logic                         hs;

  assign hdr_ns  = src_data[memDataLen-1 -: logMemNamespaces];
  assign hdr_pe  = src_data[cntLen +: logNumPeMemColumn];
  assign hdr_cnt = src_data[cntLen-1:0];

  // Ready is a pure decode of the state register, so it changes only on clock edges.
  assign src_ready = (state == HDR) || (state == BURST);
  assign busy      = (state != IDLE);
  assign hs        = src_valid && src_ready;

  // NOTE: every register here uses non-blocking assignment so all of them see pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      ns_q           <= '0;
      pe_q           <= '0;
      cnt            <= '0;
      mem_wrt_valid  <= 1'b0;
      peId_mem_in    <= '0;
      mem_data_type  <= '0;
      mem_data_input <= '0;
      start          <= 1'b0;
      words_written  <= '0;
`ifdef PE_MEM_LOADER_CHECKSUM_EN
      checksum       <= '0;
`endif
    end else begin
      // Strobes default low; the write fields are left alone so they hold between writes.
      mem_wrt_valid <= 1'b0;
      start         <= 1'b0;
      unique case (state)
        IDLE: begin
          if (load_go) begin
            state         <= HDR;
            words_written <= '0;
`ifdef PE_MEM_LOADER_CHECKSUM_EN
            checksum      <= '0;
`endif
          end
        end
        HDR: begin
          if (hs) begin
            if (hdr_cnt == '0) begin
              state <= FIN;
            end else begin
              ns_q  <= hdr_ns;
              pe_q  <= hdr_pe;
              cnt   <= hdr_cnt;
              state <= BURST;
            end
          end
        end
        BURST: begin
          if (hs) begin
            mem_wrt_valid  <= 1'b1;
            mem_data_input <= src_data;
            peId_mem_in    <= pe_q;
            mem_data_type  <= ns_q;
            cnt            <= cnt - cntLen'(1);
            words_written  <= words_written + 16'd1;
`ifdef PE_MEM_LOADER_CHECKSUM_EN
            checksum       <= checksum + src_data;
`endif
            if (cnt == cntLen'(1)) state <= HDR;
          end
        end
        FIN: begin
          start <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_mem_loader.sv
// Directed self-checking bench for pe_mem_loader; a negedge monitor logs every write and start pulse.
module tb_pe_mem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load_go = 1'b0;
  logic [15:0] src_data = '0;
  logic        src_valid = 1'b0;
  logic        src_ready;
  logic        mem_wrt_valid;
  logic [1:0]  peId_mem_in;
  logic [1:0]  mem_data_type;
  logic [15:0] mem_data_input;
  logic        start;
  logic        busy;
  logic [15:0] words_written;
`ifdef PE_MEM_LOADER_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  pe_mem_loader dut (
    .clk            (clk),
    .reset          (reset),
    .load_go        (load_go),
    .src_data       (src_data),
    .src_valid      (src_valid),
    .src_ready      (src_ready),
    .mem_wrt_valid  (mem_wrt_valid),
    .peId_mem_in    (peId_mem_in),
    .mem_data_type  (mem_data_type),
    .mem_data_input (mem_data_input),
    .start          (start),
    .busy           (busy),
    .words_written  (words_written)
`ifdef PE_MEM_LOADER_CHECKSUM_EN
    ,
    .checksum       (checksum)
`endif
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  int          cyc = 0;
  logic [19:0] wq[$];
  int          wc[$];
  int          start_cnt = 0;
  int          start_cyc = 0;
  int          overlap = 0;
  int          s0;

  always @(posedge clk) cyc <= cyc + 1;

  // Log each visible write as {type, pe, data} with the cycle it appeared on.
  always @(negedge clk) begin
    if (mem_wrt_valid === 1'b1) begin
      wq.push_back({mem_data_type, peId_mem_in, mem_data_input});
      wc.push_back(cyc);
    end
    if (start === 1'b1) begin
      start_cnt++;
      start_cyc = cyc;
      if (mem_wrt_valid === 1'b1) overlap++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else passed++;
  endtask

  function automatic logic [31:0] wr(input logic [1:0] t, input logic [1:0] p, input logic [15:0] d);
    return {12'd0, t, p, d};
  endfunction

  task automatic push(input logic [15:0] w);
    bit hs = 1'b0;
    src_data  = w;
    src_valid = 1'b1;
    for (int i = 0; i < 20 && !hs; i++) begin
      @(negedge clk);
      hs = src_ready;
      @(posedge clk);
      #1;
    end
    check("push_handshake", 32'(hs), 32'd1);
    src_valid = 1'b0;
  endtask

  task automatic bubble();
    src_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic go();
    load_go = 1'b1;
    @(posedge clk);
    #1;
    load_go = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("idle_timeout", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wq.delete();
    wc.delete();
    s0 = start_cnt;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_strobes", 32'({mem_wrt_valid, start, busy, src_ready}), 32'd0);
    check("rst_fields", 32'({mem_data_type, peId_mem_in, mem_data_input}), 32'd0);
    check("rst_words", 32'(words_written), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("idle_ready", 32'(src_ready), 32'd0);

    // Test 1: two type-1 writes then end marker
    clear_log();
    go();
    check("t1_busy", 32'(busy), 32'd1);
    push(16'h4002); push(16'h0012); push(16'h0056); push(16'h0000);
    wait_idle();
    check("t1_nwr", 32'(wq.size()), 32'd2);
    check("t1_wr0", 32'(wq[0]), wr(2'd1, 2'd0, 16'h0012));
    check("t1_wr1", 32'(wq[1]), wr(2'd1, 2'd0, 16'h0056));
    check("t1_consec", 32'(wc[1] - wc[0]), 32'd1);
    check("t1_starts", 32'(start_cnt - s0), 32'd1);
    check("t1_start_lat", 32'(start_cyc - wc[1]), 32'd2);
    check("t1_words", 32'(words_written), 32'd2);
    check("t1_hold_data", 32'(mem_data_input), 32'h0056);

    // Test 2: back-to-back bursts, different namespace and PE
    clear_log();
    go();
    push(16'h8003); push(16'h0034); push(16'h0078); push(16'h009A);
    push(16'hF001); push(16'h0012); push(16'h0000);
    wait_idle();
    check("t2_nwr", 32'(wq.size()), 32'd4);
    check("t2_wr0", 32'(wq[0]), wr(2'd2, 2'd0, 16'h0034));
    check("t2_wr1", 32'(wq[1]), wr(2'd2, 2'd0, 16'h0078));
    check("t2_wr2", 32'(wq[2]), wr(2'd2, 2'd0, 16'h009A));
    check("t2_wr3", 32'(wq[3]), wr(2'd3, 2'd3, 16'h0012));
    check("t2_burst_run", 32'(wc[2] - wc[0]), 32'd2);
    check("t2_hdr_gap", 32'(wc[3] - wc[2]), 32'd2);
    check("t2_starts", 32'(start_cnt - s0), 32'd1);
    check("t2_start_lat", 32'(start_cyc - wc[3]), 32'd2);
    check("t2_words", 32'(words_written), 32'd4);
    check("t2_hold_pe", 32'({mem_data_type, peId_mem_in}), 32'hF);
`ifdef PE_MEM_LOADER_CHECKSUM_EN
    check("t2_checksum", 32'(checksum), 32'h0158);
`endif

    // Test 3: payload with bubbles
    clear_log();
    go();
    push(16'h4003); push(16'h0001); bubble(); push(16'h0002); bubble(); push(16'h0003);
    push(16'h0000);
    wait_idle();
    check("t3_nwr", 32'(wq.size()), 32'd3);
    check("t3_wr0", 32'(wq[0]), wr(2'd1, 2'd0, 16'h0001));
    check("t3_wr1", 32'(wq[1]), wr(2'd1, 2'd0, 16'h0002));
    check("t3_wr2", 32'(wq[2]), wr(2'd1, 2'd0, 16'h0003));
    check("t3_gap0", 32'(wc[1] - wc[0]), 32'd2);
    check("t3_gap1", 32'(wc[2] - wc[1]), 32'd2);
    check("t3_words", 32'(words_written), 32'd3);
    check("t3_starts", 32'(start_cnt - s0), 32'd1);

    // Test 4: immediate end marker
    clear_log();
    go();
    push(16'h0000);
    wait_idle();
    check("t4_nwr", 32'(wq.size()), 32'd0);
    check("t4_starts", 32'(start_cnt - s0), 32'd1);
    check("t4_words", 32'(words_written), 32'd0);

    // Test 6: load_go while in BURST is ignored
    clear_log();
    go();
    push(16'h4003); push(16'h0005);
    go();
    check("t6_busy", 32'(busy), 32'd1);
    check("t6_words_mid", 32'(words_written), 32'd1);
    push(16'h0006); push(16'h0007); push(16'h0000);
    wait_idle();
    check("t6_nwr", 32'(wq.size()), 32'd3);
    check("t6_words", 32'(words_written), 32'd3);
    check("t6_starts", 32'(start_cnt - s0), 32'd1);

    // Test 5: reset in the middle of a burst
    clear_log();
    go();
    push(16'h4004); push(16'h0011);
    src_data  = 16'h0022;
    src_valid = 1'b1;
    check("t5_pre_write", 32'(mem_wrt_valid), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("t5_rst_strobes", 32'({mem_wrt_valid, start, busy, src_ready}), 32'd0);
    check("t5_rst_fields", 32'({mem_data_type, peId_mem_in, mem_data_input}), 32'd0);
    check("t5_rst_words", 32'(words_written), 32'd0);
    src_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("t5_no_start", 32'(start_cnt - s0), 32'd0);
    check("t5_idle", 32'({busy, src_ready}), 32'd0);

    check("start_overlap", 32'(overlap), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
